// File: rtl/jive_boot_copier.sv
// jive_boot_copier: boot-time copy engine. Reads WORD_CNT words from the boot ROM
// over a csel/rden/dtack port and writes them to a RAM slave over a dtack-handshaked
// write port, holding the CPU in reset until the copy has completed.
//
// Handshake (both ports): the copier raises csel plus rden/wren and keeps them, with a
// stable address, until it samples dtack=1 on an enabled cycle. It then drops the
// request and waits in a gap state until the slave's dtack has fallen, so one enabled
// cycle always separates two requests on the same port. A dtack on an idle port is ignored.
module jive_boot_copier #(
   parameter logic [7:0]  SRC_BASE   = 8'h00,
   parameter int unsigned WORD_CNT   = 192,
   parameter logic [31:0] DST_BASE   = 32'h8000_0000,
   parameter int unsigned TMO_CYC    = 255,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cpu_hold,
   output logic        src_csel,
   output logic        src_rden,
   output logic [7:0]  src_addr,
   input  logic [31:0] src_rdata,
   input  logic        src_dtack,
   output logic        dst_csel,
   output logic        dst_wren,
   output logic [31:0] dst_addr,
   output logic [31:0] dst_wdata,
   output logic [3:0]  dst_bena,
   input  logic        dst_dtack
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      RD_GAP = 3'd2,
      WR_REQ = 3'd3,
      WR_GAP = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   // Word count needs 9 bits so that a full 256-word copy can be recognised.
   localparam logic [8:0] CNT_END  = 9'(WORD_CNT);
   // The timeout fires on the TMO_CYC-th enabled cycle spent in one state.
   localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

   state_t     state;
   logic [8:0] count;
   logic [7:0] tmo_cnt;
   logic       first_cyc;

   // Timeout is reached on this cycle when the counter already holds TMO_CYC-1.
   logic tmo_hit;
   assign tmo_hit = (tmo_cnt == TMO_LAST);

   // Copy sequencer: every output is registered here; rst overrides clk_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         cpu_hold  <= 1'b1;
         src_csel  <= 1'b0;
         src_rden  <= 1'b0;
         src_addr  <= SRC_BASE;
         dst_csel  <= 1'b0;
         dst_wren  <= 1'b0;
         dst_addr  <= DST_BASE;
         dst_wdata <= 32'h0;
         dst_bena  <= 4'h0;
         count     <= 9'd0;
         tmo_cnt   <= 8'd0;
         first_cyc <= 1'b1;
      end else if (clk_en) begin
         first_cyc <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               // Auto start only applies to the very first enabled cycle after rst.
               if (start || (state == IDLE && AUTO_START && first_cyc)) begin
                  state    <= RD_REQ;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  count    <= 9'd0;
                  tmo_cnt  <= 8'd0;
                  src_csel <= 1'b1;
                  src_rden <= 1'b1;
                  src_addr <= SRC_BASE;
               end
            end

            RD_REQ: begin
               if (src_dtack) begin
                  dst_wdata <= src_rdata;
                  src_csel  <= 1'b0;
                  src_rden  <= 1'b0;
                  tmo_cnt   <= 8'd0;
                  state     <= RD_GAP;
               end else if (tmo_hit) begin
                  src_csel <= 1'b0;
                  src_rden <= 1'b0;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  state    <= ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            RD_GAP: begin
               // The ROM holds dtack while it still sees a request; wait for it to fall.
               if (!src_dtack) begin
                  dst_csel <= 1'b1;
                  dst_wren <= 1'b1;
                  dst_bena <= 4'hF;
                  dst_addr <= DST_BASE + {21'd0, count, 2'b00};
                  tmo_cnt  <= 8'd0;
                  state    <= WR_REQ;
               end else if (tmo_hit) begin
                  busy  <= 1'b0;
                  error <= 1'b1;
                  state <= ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            WR_REQ: begin
               if (dst_dtack) begin
                  dst_csel <= 1'b0;
                  dst_wren <= 1'b0;
                  dst_bena <= 4'h0;
                  count    <= count + 9'd1;
                  tmo_cnt  <= 8'd0;
                  state    <= WR_GAP;
               end else if (tmo_hit) begin
                  dst_csel <= 1'b0;
                  dst_wren <= 1'b0;
                  dst_bena <= 4'h0;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  state    <= ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            WR_GAP: begin
               if (!dst_dtack) begin
                  tmo_cnt <= 8'd0;
                  if (count == CNT_END) begin
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     state    <= DONE;
                  end else begin
                     // ROM address wraps modulo 256 by truncation to 8 bits.
                     src_csel <= 1'b1;
                     src_rden <= 1'b1;
                     src_addr <= SRC_BASE + count[7:0];
                     state    <= RD_REQ;
                  end
               end else if (tmo_hit) begin
                  busy  <= 1'b0;
                  error <= 1'b1;
                  state <= ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            default: begin
               src_csel <= 1'b0;
               src_rden <= 1'b0;
               dst_csel <= 1'b0;
               dst_wren <= 1'b0;
               dst_bena <= 4'h0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jive_boot_copier.sv
// Directed bench for jive_boot_copier: 4-word copy from ROM base 0xFE (address wrap),
// with behavioural ROM/RAM slaves that log every acknowledged access.
module tb_jive_boot_copier;

   localparam logic [31:0] DST = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, error, cpu_hold;
   logic        src_csel, src_rden;
   logic [7:0]  src_addr;
   logic [31:0] src_rdata;
   logic        src_dtack;
   logic        dst_csel, dst_wren;
   logic [31:0] dst_addr, dst_wdata;
   logic [3:0]  dst_bena;
   logic        dst_dtack;

   int checks = 0;
   int failures = 0;

   // slave behaviour controls
   bit ram_dead = 1'b0;
   bit slow_word2 = 1'b0;

   // access logs
   logic [7:0]  rd_log [$];
   logic [31:0] wa_log [$];
   logic [31:0] wd_log [$];
   logic [3:0]  wb_log [$];
   int src_req_cnt = 0;
   int dst_req_cnt = 0;
   logic src_csel_q = 1'b0;
   logic dst_csel_q = 1'b0;
   int wait_cnt = 0;

   logic [7:0]  exp_rd   [4];
   logic [31:0] exp_data [4];

   always #5 clk = ~clk;

   jive_boot_copier #(
      .SRC_BASE  (8'hFE),
      .WORD_CNT  (4),
      .DST_BASE  (DST),
      .TMO_CYC   (16),
      .AUTO_START(1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .cpu_hold (cpu_hold),
      .src_csel (src_csel),
      .src_rden (src_rden),
      .src_addr (src_addr),
      .src_rdata(src_rdata),
      .src_dtack(src_dtack),
      .dst_csel (dst_csel),
      .dst_wren (dst_wren),
      .dst_addr (dst_addr),
      .dst_wdata(dst_wdata),
      .dst_bena (dst_bena),
      .dst_dtack(dst_dtack)
   );

   function automatic logic [31:0] rom_word(input logic [7:0] a);
      case (a)
         8'hFE:   return 32'h0000_0093;
         8'hFF:   return 32'h0000_0113;
         8'h00:   return 32'h0000_0193;
         8'h01:   return 32'h0000_0213;
         default: return {24'hDEAD00, a};
      endcase
   endfunction

   // ROM: one-cycle registered acknowledge pulse per request
   always @(posedge clk) begin
      if (rst) begin
         src_dtack <= 1'b0;
         src_rdata <= 32'h0;
         src_csel_q <= 1'b0;
      end else if (clk_en) begin
         src_csel_q <= src_csel;
         if (src_csel && !src_csel_q) src_req_cnt <= src_req_cnt + 1;
         src_dtack <= src_csel & src_rden & ~src_dtack;
         if (src_csel && src_rden && !src_dtack) begin
            src_rdata <= rom_word(src_addr);
            rd_log.push_back(src_addr);
         end
      end
   end

   // RAM: acknowledge after 1 enabled cycle (10 for word 2 when slow), or never when dead
   always @(posedge clk) begin
      if (rst) begin
         dst_dtack <= 1'b0;
         wait_cnt <= 0;
         dst_csel_q <= 1'b0;
      end else if (clk_en) begin
         dst_csel_q <= dst_csel;
         if (dst_csel && !dst_csel_q) dst_req_cnt <= dst_req_cnt + 1;
         if (dst_csel && dst_wren && !dst_dtack && !ram_dead) begin
            if (wait_cnt >= ((slow_word2 && dst_addr == DST + 32'd8) ? 9 : 0)) begin
               dst_dtack <= 1'b1;
               wait_cnt <= 0;
               wa_log.push_back(dst_addr);
               wd_log.push_back(dst_wdata);
               wb_log.push_back(dst_bena);
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end else begin
            dst_dtack <= 1'b0;
            wait_cnt <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Runs until done (or error) is seen; counts enabled and raw clock cycles.
   task automatic run_copy(input bit toggle, input bit do_start, input bit want_err,
                           input int limit, output int n_en, output int n_clk);
      n_en = 0;
      n_clk = 0;
      while (n_clk < limit) begin
         clk_en = toggle ? n_clk[0] : 1'b1;
         start = (do_start && n_en == 0 && clk_en) ? 1'b1 : 1'b0;
         @(posedge clk);
         n_clk++;
         if (clk_en) n_en++;
         @(negedge clk);
         start = 1'b0;
         if (want_err ? error : done) break;
      end
      clk_en = 1'b1;
   endtask

   // Compares logged accesses from the given log positions against the expected copy.
   task automatic check_copy(input string tag, input int rb, input int wb);
      chk({tag, "_nrd"}, 32'(rd_log.size() - rb), 32'd4);
      chk({tag, "_nwr"}, 32'(wa_log.size() - wb), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (rb + i < rd_log.size())
            chk($sformatf("%s_rdaddr%0d", tag, i), 32'(rd_log[rb+i]), 32'(exp_rd[i]));
         if (wb + i < wa_log.size()) begin
            chk($sformatf("%s_wraddr%0d", tag, i), wa_log[wb+i], DST + 32'(4 * i));
            chk($sformatf("%s_wrdata%0d", tag, i), wd_log[wb+i], exp_data[i]);
            chk($sformatf("%s_bena%0d", tag, i), 32'(wb_log[wb+i]), 32'hF);
         end
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n_en, n_clk, rb, wb, sr, sd;
      bit found;
      exp_rd[0] = 8'hFE; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00; exp_rd[3] = 8'h01;
      exp_data[0] = 32'h93; exp_data[1] = 32'h113; exp_data[2] = 32'h193; exp_data[3] = 32'h213;

      // reset values
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", 32'({busy, done, error, cpu_hold, src_csel, src_rden, dst_csel, dst_wren}),
          32'b0001_0000);
      chk("reset_src_addr", 32'(src_addr), 32'hFE);
      chk("reset_dst_addr", dst_addr, DST);
      chk("reset_wdata", dst_wdata, 32'h0);
      chk("reset_bena", 32'(dst_bena), 32'h0);

      // auto-start copy: done 25 enabled cycles after rst release
      rb = rd_log.size(); wb = wa_log.size(); sr = src_req_cnt; sd = dst_req_cnt;
      rst = 1'b0;
      run_copy(1'b0, 1'b0, 1'b0, 200, n_en, n_clk);
      chk("auto_cycles", 32'(n_en), 32'd25);
      chk("auto_flags", 32'({busy, done, error, cpu_hold}), 32'b0100);
      check_copy("auto", rb, wb);
      chk("auto_src_reqs", 32'(src_req_cnt - sr), 32'd4);
      chk("auto_dst_reqs", 32'(dst_req_cnt - sd), 32'd4);

      // clk_en toggling every cycle
      rst = 1'b1;
      @(negedge clk);
      chk("rerst_hold", 32'({cpu_hold, done}), 32'b10);
      rb = rd_log.size(); wb = wa_log.size(); sr = src_req_cnt; sd = dst_req_cnt;
      rst = 1'b0;
      run_copy(1'b1, 1'b0, 1'b0, 400, n_en, n_clk);
      chk("tog_en_cycles", 32'(n_en), 32'd25);
      chk("tog_clk_cycles", 32'(n_clk), 32'd50);
      chk("tog_done", 32'(done), 32'd1);
      check_copy("tog", rb, wb);
      chk("tog_src_reqs", 32'(src_req_cnt - sr), 32'd4);
      chk("tog_dst_reqs", 32'(dst_req_cnt - sd), 32'd4);

      // restart from DONE with word 2 acknowledged 10 cycles late
      slow_word2 = 1'b1;
      rb = rd_log.size(); wb = wa_log.size();
      run_copy(1'b0, 1'b1, 1'b0, 300, n_en, n_clk);
      slow_word2 = 1'b0;
      chk("slow_cycles", 32'(n_en), 32'd34);
      chk("slow_flags", 32'({busy, done, error, cpu_hold}), 32'b0100);
      check_copy("slow", rb, wb);

      // RAM never acknowledges: timeout after 16 enabled cycles in WR_REQ
      ram_dead = 1'b1;
      pulse_rst();
      run_copy(1'b0, 1'b0, 1'b1, 200, n_en, n_clk);
      chk("tmo_cycles", 32'(n_en), 32'd20);
      chk("tmo_flags", 32'({busy, done, error, cpu_hold}), 32'b0011);
      chk("tmo_req_drop", 32'({src_csel, dst_csel, dst_wren}), 32'b000);
      ram_dead = 1'b0;
      repeat (3) @(negedge clk);
      chk("tmo_sticky", 32'(error), 32'd1);
      rb = rd_log.size(); wb = wa_log.size();
      run_copy(1'b0, 1'b1, 1'b0, 200, n_en, n_clk);
      chk("retry_cycles", 32'(n_en), 32'd25);
      chk("retry_flags", 32'({busy, done, error, cpu_hold}), 32'b0100);
      check_copy("retry", rb, wb);

      // rst during WR_REQ of word 1 (with clk_en low), then auto-restart
      pulse_rst();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (dst_csel && dst_addr == DST + 32'd4) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("mid_found_wr1", 32'(found), 32'd1);
      rst = 1'b1;
      clk_en = 1'b0;
      @(negedge clk);
      chk("mid_ctrl", 32'({busy, done, error, cpu_hold, src_csel, src_rden, dst_csel, dst_wren}),
          32'b0001_0000);
      chk("mid_dst_addr", dst_addr, DST);
      chk("mid_wdata", dst_wdata, 32'h0);
      chk("mid_bena", 32'(dst_bena), 32'h0);
      clk_en = 1'b1;
      @(negedge clk);
      rb = rd_log.size(); wb = wa_log.size();
      rst = 1'b0;
      run_copy(1'b0, 1'b0, 1'b0, 200, n_en, n_clk);
      chk("mid_cycles", 32'(n_en), 32'd25);
      chk("mid_flags", 32'({busy, done, error, cpu_hold}), 32'b0100);
      check_copy("mid", rb, wb);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule

// File: doc/jive_boot_copier.md
Name: jive_boot_copier

Overview:
- Bus initiator that drives the boot ROM's csel/rden/addr/rdata/dtack slave interface. It is the requester on that interface, with the ROM as responder.
- After reset or a start pulse, it reads WORD_CNT consecutive 32-bit words from the ROM and writes each word to a destination RAM slave over a dtack-handshaked write port.
- It holds the CPU in reset (cpu_hold) until the copy completes, so the CPU boots from RAM.

Parameters:
- SRC_BASE, 8'h00, first ROM word address.
- WORD_CNT, 192, number of words to copy (1..256).
- DST_BASE, 32'h8000_0000, first destination byte address (word aligned).
- TMO_CYC, 255, clk_en-qualified cycles to wait for any dtack before aborting (1..255).
- AUTO_START, 1, 1 = begin copy on the first enabled cycle after reset; 0 = wait for start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  clock enable; all state advances only when clk_en=1
- start  in  1  single-cycle copy request; ignored unless in IDLE, DONE or ERR
- busy  out  1  copy in progress
- done  out  1  copy finished OK; sticky until next start or rst
- error  out  1  dtack timeout; sticky until next start or rst
- cpu_hold  out  1  CPU reset request; 1 from reset until done=1
- src_csel  out  1  ROM chip select
- src_rden  out  1  ROM read enable
- src_addr  out  8  ROM word address
- src_rdata  in  32  ROM read data, valid when src_dtack=1
- src_dtack  in  1  ROM acknowledge, registered, one enabled cycle after request
- dst_csel  out  1  RAM chip select
- dst_wren  out  1  RAM write enable
- dst_addr  out  32  RAM byte address
- dst_wdata  out  32  RAM write data
- dst_bena  out  4  byte enables; always 4'hF during a write
- dst_dtack  in  1  RAM acknowledge

Behaviour:
- Reset values: busy=0, done=0, error=0, cpu_hold=1, all csel/rden/wren=0, src_addr=SRC_BASE, dst_addr=DST_BASE, dst_wdata=0, dst_bena=0, word counter=0, timeout counter=0, state=IDLE.
- Gating: when clk_en=0, all registers hold, including the timeout counter. start is sampled only on enabled cycles.
- IDLE: go to RD_REQ if (AUTO_START and first enabled cycle after rst) or start=1. Entering RD_REQ sets busy=1 and clears done/error.
- RD_REQ: drive src_csel=src_rden=1 with src_addr = SRC_BASE + count (8-bit, wraps modulo 256).
  - On src_dtack=1: capture src_rdata into dst_wdata, drop src_csel/src_rden, go to RD_GAP.
- RD_GAP: request is deasserted. Wait for src_dtack=0, because the ROM keeps dtack high while the request is held. Then go to WR_REQ.
- WR_REQ: drive dst_csel=dst_wren=1, dst_bena=4'hF, dst_addr = DST_BASE + 4*count (32-bit wrap).
  - On dst_dtack=1: deassert, increment count, go to WR_GAP.
- WR_GAP: wait for dst_dtack=0. If count==WORD_CNT go to DONE, else go to RD_REQ.
- Back-to-back requests are forbidden. At least one enabled cycle always separates consecutive requests on each port.
- DONE: busy=0, done=1, cpu_hold=0. A start here restarts the copy but leaves cpu_hold=0; cpu_hold rises again only on rst.
- Timeout: the counter clears on every state entry and increments on each enabled cycle spent in RD_REQ, RD_GAP, WR_REQ or WR_GAP.
  - Reaching TMO_CYC goes to ERR: all requests drop, busy=0, error=1, cpu_hold stays 1.
  - From ERR, start retries from word 0.
- Latency: with the ROM and a one-cycle-dtack RAM, each word takes 6 enabled cycles: RD_REQ 2, RD_GAP 1, WR_REQ 2, WR_GAP 1.
  - Start to done is 6*WORD_CNT + 1 enabled cycles.
- start during busy is ignored. start on the same cycle as rst: rst wins.
- rst mid-copy: all requests drop on the next clk edge regardless of clk_en, and the state returns to reset values. No partial-word write is retried.
- A dtack on a port that is not requesting is ignored, except that RD_GAP/WR_GAP wait for it to fall.

Test Plan:
- Copy, WORD_CNT=4, ROM words 0x00000093, 0x00000113, 0x00000193, 0x00000213:
  - RAM gets the same data at 0x80000000, 0x80000004, 0x80000008, 0x8000000C with bena=F.
  - done rises and cpu_hold falls 25 enabled cycles after rst release.
- clk_en toggling 1/0 every cycle: same result, with the 25 enabled cycles stretched to 50 clk cycles; no extra or duplicate requests.
- RAM dtack delayed 10 cycles for word 2: the copy still completes and total time grows by 9 enabled cycles.
- RAM never asserts dtack, TMO_CYC=16: error=1 after 16 enabled cycles in WR_REQ, busy=0, cpu_hold=1. A following start with a working RAM gives done=1.
- rst asserted in WR_REQ of word 1: dst_csel=0 on the next edge and outputs return to reset values. Auto-restart then copies all words from 0.
- SRC_BASE=8'hFE, WORD_CNT=4: ROM addresses FE, FF, 00, 01 are read in order, and destination addresses increment by 4 without wrap.
